// File: rtl/mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp
// Purpose  : Memory-side responder for the MA-stage load/store handshake.
//            Accepts level read/write requests, services them from an
//            internal byte-addressed little-endian RAM after a fixed
//            latency, and returns one-cycle ack pulses.
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset
//            co_re    - read request level (held until co_rack)
//            co_rlen  - read size: 00 byte, 01 half, 11 word, 10 reserved
//            m_raddr  - read byte address
//            mem_in   - read data, zero-extended
//            co_rack  - one-cycle read acknowledge
//            co_we    - write request level (held until co_wack)
//            co_wlen  - write size, same encoding as co_rlen
//            m_waddr  - write byte address
//            mem_out  - write data, low bytes used per size
//            co_wack  - one-cycle write acknowledge
//            err      - pulse alongside the ack of a faulted request
// Options  : MEM_ALIGN_CHK_EN - when defined, misaligned half/word accesses
//            are faulted instead of being performed bytewise.
// Notes    : DATA_L is expected to be 32 (four byte lanes).
// Revision : 1.0 - initial release
// ============================================================================
module mem_resp #(
    parameter int MADDR_L = 32,
    parameter int DATA_L  = 32,
    parameter int MEM_AW  = 12,
    parameter int RD_LAT  = 2,
    parameter int WR_LAT  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               co_re,
    input  logic [1:0]         co_rlen,
    input  logic [MADDR_L-1:0] m_raddr,
    output logic [DATA_L-1:0]  mem_in,
    output logic               co_rack,
    input  logic               co_we,
    input  logic [1:0]         co_wlen,
    input  logic [MADDR_L-1:0] m_waddr,
    input  logic [DATA_L-1:0]  mem_out,
    output logic               co_wack,
    output logic               err
);

    localparam int c_MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int c_CNT_W   = (c_MAX_LAT > 1) ? $clog2(c_MAX_LAT) : 1;
    localparam int c_MEM_SZ  = 1 << MEM_AW;

    localparam logic [c_CNT_W-1:0] c_RD_INIT = c_CNT_W'(RD_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_WR_INIT = c_CNT_W'(WR_LAT - 1);

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b11;
    localparam logic [1:0] c_SZ_RSVD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RBUSY = 3'd1,
        S_WBUSY = 3'd2,
        S_RACK  = 3'd3,
        S_WACK  = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [c_CNT_W-1:0]   r_cnt;
    logic [MEM_AW-1:0]    r_addr;
    logic [1:0]           r_len;
    logic [DATA_L-1:0]    r_wdata;
    logic                 r_is_wr;   // direction of the request being serviced

    logic [7:0]           r_mem [0:c_MEM_SZ-1];

    logic                 w_done;
    logic                 w_misalign;
    logic                 w_fault;
    logic                 w_rd_fire;
    logic                 w_wr_fire;
    logic [MEM_AW-1:0]    w_a0;
    logic [MEM_AW-1:0]    w_a1;
    logic [MEM_AW-1:0]    w_a2;
    logic [MEM_AW-1:0]    w_a3;
    logic [31:0]          w_rdata;

    // Address bits above MEM_AW alias onto the RAM and are deliberately dropped.
    logic                 w_unused_addr_hi;
    assign w_unused_addr_hi = ^{m_raddr[MADDR_L-1:MEM_AW], m_waddr[MADDR_L-1:MEM_AW]};

    // ------------------------------------------------------------------------
    // Fault decode on the latched request
    // ------------------------------------------------------------------------
`ifdef MEM_ALIGN_CHK_EN
    assign w_misalign = ((r_len == c_SZ_HALF) && r_addr[0]) ||
                        ((r_len == c_SZ_WORD) && (r_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault   = (r_len == c_SZ_RSVD) || w_misalign;
    assign w_done    = (r_cnt == '0);
    assign w_rd_fire = (r_state == S_RBUSY) && w_done;
    assign w_wr_fire = (r_state == S_WBUSY) && w_done;

    // Byte lane addresses wrap modulo the RAM size.
    assign w_a0 = r_addr;
    assign w_a1 = r_addr + MEM_AW'(1);
    assign w_a2 = r_addr + MEM_AW'(2);
    assign w_a3 = r_addr + MEM_AW'(3);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                // Write wins when both requests are up; the read stays
                // pending and is picked up after the write's HOLD.
                if (co_we) begin
                    w_next = S_WBUSY;
                end else if (co_re) begin
                    w_next = S_RBUSY;
                end
            end
            S_RBUSY: if (w_done) w_next = S_RACK;
            S_WBUSY: if (w_done) w_next = S_WACK;
            S_RACK:  w_next = S_HOLD;
            S_WACK:  w_next = S_HOLD;
            S_HOLD: begin
                // Wait for the serviced level request to drop so it is not
                // taken a second time.
                if (r_is_wr ? !co_we : !co_re) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign co_rack = (r_state == S_RACK);
    assign co_wack = (r_state == S_WACK);
    assign err     = (co_rack || co_wack) && w_fault;

    // ------------------------------------------------------------------------
    // Request latch, latency counter and read data register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_len   <= c_SZ_BYTE;
            r_wdata <= '0;
            r_is_wr <= 1'b0;
            mem_in  <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                if (co_we) begin
                    r_addr  <= m_waddr[MEM_AW-1:0];
                    r_len   <= co_wlen;
                    r_wdata <= mem_out;
                    r_is_wr <= 1'b1;
                    r_cnt   <= c_WR_INIT;
                end else if (co_re) begin
                    r_addr  <= m_raddr[MEM_AW-1:0];
                    r_len   <= co_rlen;
                    r_is_wr <= 1'b0;
                    r_cnt   <= c_RD_INIT;
                end
            end else if ((r_state == S_RBUSY || r_state == S_WBUSY) && !w_done) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_rd_fire) begin
                mem_in <= w_fault ? '0 : DATA_L'(w_rdata);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read byte assembly (little-endian, zero-extended)
    // ------------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        case (r_len)
            c_SZ_BYTE: w_rdata = {24'h0, r_mem[w_a0]};
            c_SZ_HALF: w_rdata = {16'h0, r_mem[w_a1], r_mem[w_a0]};
            c_SZ_WORD: w_rdata = {r_mem[w_a3], r_mem[w_a2], r_mem[w_a1], r_mem[w_a0]};
            default:   w_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // RAM write port. Contents survive reset; an in-flight write is lost
    // because reset forces the FSM out of WBUSY before it can fire.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_fire && !w_fault) begin
            r_mem[w_a0] <= r_wdata[7:0];
            if (r_len == c_SZ_HALF || r_len == c_SZ_WORD) begin
                r_mem[w_a1] <= r_wdata[15:8];
            end
            if (r_len == c_SZ_WORD) begin
                r_mem[w_a2] <= r_wdata[23:16];
                r_mem[w_a3] <= r_wdata[31:24];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_resp
// Purpose  : Directed self-checking bench for mem_resp. Expected values are
//            hand-computed from the little-endian RAM behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_resp;

    localparam int MADDR_L = 32;
    localparam int DATA_L  = 32;
    localparam int MEM_AW  = 12;
    localparam int RD_LAT  = 2;
    localparam int WR_LAT  = 2;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b11;
    localparam logic [1:0] SZ_R = 2'b10;

    logic               clk;
    logic               rst_n;
    logic               co_re;
    logic [1:0]         co_rlen;
    logic [MADDR_L-1:0] m_raddr;
    logic [DATA_L-1:0]  mem_in;
    logic               co_rack;
    logic               co_we;
    logic [1:0]         co_wlen;
    logic [MADDR_L-1:0] m_waddr;
    logic [DATA_L-1:0]  mem_out;
    logic               co_wack;
    logic               err;

    int n_asrt = 0;
    int n_fail = 0;

    mem_resp #(
        .MADDR_L (MADDR_L),
        .DATA_L  (DATA_L),
        .MEM_AW  (MEM_AW),
        .RD_LAT  (RD_LAT),
        .WR_LAT  (WR_LAT)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .co_re   (co_re),
        .co_rlen (co_rlen),
        .m_raddr (m_raddr),
        .mem_in  (mem_in),
        .co_rack (co_rack),
        .co_we   (co_we),
        .co_wlen (co_wlen),
        .m_waddr (m_waddr),
        .mem_out (mem_out),
        .co_wack (co_wack),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Compliant write: request held until the ack is seen, then dropped.
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [1:0] len,
                            input logic [31:0] data, input logic exp_err);
        int   n;
        logic e;
        m_waddr = addr;
        co_wlen = len;
        mem_out = data;
        co_we   = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!co_wack && n < 12);
        e     = err;
        co_we = 1'b0;
        chk({tag, "_lat"}, n, WR_LAT + 1);
        chk({tag, "_err"}, {31'h0, e}, {31'h0, exp_err});
        tick();
        chk({tag, "_pulse"}, {31'h0, co_wack}, 32'h0);
        tick();
    endtask

    // Compliant read: request held until the ack is seen, then dropped.
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] exp_data, input logic exp_err);
        int   n;
        logic e;
        m_raddr = addr;
        co_rlen = len;
        co_re   = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!co_rack && n < 12);
        e     = err;
        co_re = 1'b0;
        chk({tag, "_lat"}, n, RD_LAT + 1);
        chk({tag, "_data"}, mem_in, exp_data);
        chk({tag, "_err"}, {31'h0, e}, {31'h0, exp_err});
        tick();
        chk({tag, "_pulse"}, {31'h0, co_rack}, 32'h0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int extra;

        rst_n   = 1'b0;
        co_re   = 1'b0;
        co_rlen = SZ_B;
        m_raddr = '0;
        co_we   = 1'b0;
        co_wlen = SZ_B;
        m_waddr = '0;
        mem_out = '0;

        tick();
        tick();
        chk("rst_rack",  {31'h0, co_rack}, 32'h0);
        chk("rst_wack",  {31'h0, co_wack}, 32'h0);
        chk("rst_err",   {31'h0, err},     32'h0);
        chk("rst_memin", mem_in,           32'h0);
        rst_n = 1'b1;

        // Word write then byte read of its second byte.
        do_write("wr_word10", 32'h10, SZ_W, 32'hDEADBEEF, 1'b0);
        do_read ("rd_byte11", 32'h11, SZ_B, 32'h000000BE, 1'b0);
        do_read ("rd_half10", 32'h10, SZ_H, 32'h0000BEEF, 1'b0);

        // Half write over a zeroed word.
        do_write("wr_zero20", 32'h20, SZ_W, 32'h00000000, 1'b0);
        do_write("wr_half20", 32'h20, SZ_H, 32'hFFFF1234, 1'b0);
        do_read ("rd_word20", 32'h20, SZ_W, 32'h00001234, 1'b0);

        // Simultaneous requests: write first, read after its HOLD.
        m_waddr = 32'h30; co_wlen = SZ_B; mem_out = 32'h123456AA;
        m_raddr = 32'h30; co_rlen = SZ_B;
        co_we = 1'b1;
        co_re = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!co_wack && n < 12);
        chk("both_wlat", n, WR_LAT + 1);
        chk("both_rack_during_wack", {31'h0, co_rack}, 32'h0);
        co_we = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!co_rack && n < 16);
        chk("both_rlat", n, RD_LAT + 3);
        chk("both_data", mem_in, 32'h000000AA);
        co_re = 1'b0;
        tick();
        tick();

        // Read request held three cycles past its ack: one ack only.
        m_raddr = 32'h11; co_rlen = SZ_B; co_re = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!co_rack && n < 12);
        chk("hold_lat",  n,      RD_LAT + 1);
        chk("hold_data", mem_in, 32'h000000BE);
        extra = 0;
        repeat (3) begin
            tick();
            extra += int'(co_rack);
        end
        co_re = 1'b0;
        repeat (4) begin
            tick();
            extra += int'(co_rack);
        end
        chk("hold_single_ack", extra, 0);

        // Misaligned word read at 0x22.
        do_write("wr_word24", 32'h24, SZ_W, 32'h87654321, 1'b0);
`ifdef MEM_ALIGN_CHK_EN
        do_read ("rd_word22", 32'h22, SZ_W, 32'h00000000, 1'b1);
`else
        do_read ("rd_word22", 32'h22, SZ_W, 32'h43210000, 1'b0);
`endif

        // Reserved size: ack with err, no RAM update, read data zero.
        do_write("wr_rsvd10", 32'h10, SZ_R, 32'h00000077, 1'b1);
        do_read ("rd_after_rsvd", 32'h10, SZ_B, 32'h000000EF, 1'b0);
        do_read ("rd_rsvd10", 32'h10, SZ_R, 32'h00000000, 1'b1);

        // Upper address bits are ignored.
        do_write("wr_hi_fff", 32'h0001_0FFF, SZ_B, 32'h0000005A, 1'b0);
        do_read ("rd_hi_fff", 32'hABCD_EFFF, SZ_B, 32'h0000005A, 1'b0);

        // Request dropped before its ack is still serviced.
        m_raddr = 32'h11; co_rlen = SZ_B; co_re = 1'b1;
        tick();
        co_re = 1'b0;
        n = 1;
        while (!co_rack && n < 12) begin
            tick();
            n++;
        end
        chk("drop_lat",  n,      RD_LAT + 1);
        chk("drop_data", mem_in, 32'h000000BE);
        tick();
        tick();

        // Reset while a write is in WBUSY: the write is discarded.
        do_write("wr_byte40", 32'h40, SZ_B, 32'h00000011, 1'b0);
        do_read ("rd_pre_rst", 32'h11, SZ_B, 32'h000000BE, 1'b0);
        m_waddr = 32'h40; co_wlen = SZ_B; mem_out = 32'h00000055; co_we = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_busy_wack",  {31'h0, co_wack}, 32'h0);
        chk("rst_busy_memin", mem_in,           32'h0);
        co_we = 1'b0;
        tick();
        chk("rst_busy_wack2", {31'h0, co_wack}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_busy_wack3", {31'h0, co_wack}, 32'h0);
        tick();
        do_read ("rd_after_rst", 32'h40, SZ_B, 32'h00000011, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
